// File: rtl/bus_initiator_if.sv
// ---------------------------------------------------------------------------
// bus_initiator_if
// Groups the command, response and system-bus signals of bus_initiator.
//
// Signals:
//   cmd_valid/cmd_ready    command handshake
//   cmd_write              1 = write, 0 = read
//   cmd_addr/cmd_wdata     byte address and write data
//   cmd_wstrb              byte-lane enables for writes
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/rsp_err      read data and error flag
//   bus_we/bus_re          bus write strobes / read request
//   bus_addr/bus_wr_data   bus address and write data
//   bus_rd_data            ORed read data from all responders
//   bus_rd_ack/bus_wr_ack  responder acknowledges
//
// Modports:
//   master  the initiator side (bus_initiator)
//   slave   the command source, response sink and bus responders
// ---------------------------------------------------------------------------
interface bus_initiator_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [3:0]  bus_we;
   logic        bus_re;
   logic [31:0] bus_addr;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_rd_ack;
   logic        bus_wr_ack;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output bus_we, bus_re, bus_addr, bus_wr_data,
      input  bus_rd_data, bus_rd_ack, bus_wr_ack
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  bus_we, bus_re, bus_addr, bus_wr_data,
      output bus_rd_data, bus_rd_ack, bus_wr_ack
   );

endinterface

// File: rtl/bus_initiator.sv
// ---------------------------------------------------------------------------
// bus_initiator
// Turns one command at a time into a single system-bus read or write, waits
// for the responder's ack (or gives up after TIMEOUT cycles) and returns a
// response. Writes with no byte lanes enabled are rejected without touching
// the bus.
//
// Parameters:
//   TIMEOUT  bus cycles allowed for an ack before the access is abandoned
//            (1..65535)
//
// Ports:
//   clk      single clock for all logic
//   reset_l  asynchronous, active-low reset
//   bus      bus_initiator_if.master: command, response and bus signals
// ---------------------------------------------------------------------------
module bus_initiator #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic             clk,
   input logic             reset_l,
   bus_initiator_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic        out_of_reset;
   logic [15:0] wait_cnt;

   logic        accept;
   logic        start_bus;
   logic        bad_cmd;
   logic        got_ack;
   logic        timed_out;

   // cmd_ready must stay low while reset is held and only rise on the first
   // clock after release, so IDLE alone is not enough to advertise readiness.
   assign bus.cmd_ready = out_of_reset && (state == IDLE);
   assign bus.rsp_valid = (state == RSP);

   // Tracks whether at least one clock edge has passed since reset released.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         out_of_reset <= 1'b0;
      end else begin
         out_of_reset <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-cycle event decode. Acks only count in REQ, and an
   // ack on the final wait cycle beats the timeout.
   always_comb begin
      next_state = state;
      start_bus  = 1'b0;
      bad_cmd    = 1'b0;
      got_ack    = 1'b0;
      timed_out  = 1'b0;
      accept     = bus.cmd_valid && bus.cmd_ready;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.cmd_write && (bus.cmd_wstrb == 4'h0)) begin
                  bad_cmd    = 1'b1;
                  next_state = RSP;
               end else begin
                  start_bus  = 1'b1;
                  next_state = REQ;
               end
            end
         end
         REQ: begin
            got_ack   = bus.bus_rd_ack || bus.bus_wr_ack;
            timed_out = !got_ack && (wait_cnt == LAST_WAIT);
            if (got_ack || timed_out) begin
               next_state = RSP;
            end
         end
         RSP: begin
            if (bus.rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Bus request registers. Address and write data are only reloaded when a
   // new access starts (write data only for writes) so they do not toggle
   // while the bus is idle.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         bus.bus_re      <= 1'b0;
         bus.bus_we      <= 4'h0;
         bus.bus_addr    <= 32'h0;
         bus.bus_wr_data <= 32'h0;
      end else if (start_bus) begin
         bus.bus_addr <= bus.cmd_addr;
         bus.bus_re   <= !bus.cmd_write;
         bus.bus_we   <= bus.cmd_write ? bus.cmd_wstrb : 4'h0;
         if (bus.cmd_write) begin
            bus.bus_wr_data <= bus.cmd_wdata;
         end
      end else if (got_ack || timed_out) begin
         bus.bus_re <= 1'b0;
         bus.bus_we <= 4'h0;
      end
   end

   // Wait counter: zero on the first REQ cycle, counts REQ cycles without ack.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wait_cnt <= 16'h0;
      end else if (start_bus) begin
         wait_cnt <= 16'h0;
      end else if ((state == REQ) && !got_ack) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // Response registers, loaded only when leaving IDLE/REQ for RSP and held
   // until the next response is produced.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         bus.rsp_rdata <= 32'h0;
         bus.rsp_err   <= 1'b0;
      end else if (bad_cmd || timed_out) begin
         bus.rsp_rdata <= 32'h0;
         bus.rsp_err   <= 1'b1;
      end else if (got_ack) begin
         bus.rsp_rdata <= bus.bus_re ? bus.bus_rd_data : 32'h0;
         bus.rsp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_initiator
// Directed bench for bus_initiator (TIMEOUT = 4). Inputs are driven and
// outputs sampled on the falling clock edge; "cycle n" below is the clock
// period after the n-th rising edge counted from the accept edge.
// ---------------------------------------------------------------------------
module tb_bus_initiator;

   logic        clk = 1'b0;
   logic        reset_l;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] last_addr;

   bus_initiator_if bif();

   bus_initiator #(.TIMEOUT(4)) dut (
      .clk     (clk),
      .reset_l (reset_l),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bif.cmd_valid   = 1'b0;
      bif.cmd_write   = 1'b0;
      bif.cmd_addr    = 32'h0;
      bif.cmd_wdata   = 32'h0;
      bif.cmd_wstrb   = 4'h0;
      bif.rsp_ready   = 1'b0;
      bif.bus_rd_data = 32'h0;
      bif.bus_rd_ack  = 1'b0;
      bif.bus_wr_ack  = 1'b0;
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
      bif.cmd_valid = 1'b1;
      bif.cmd_write = wr;
      bif.cmd_addr  = addr;
      bif.cmd_wdata = wdata;
      bif.cmd_wstrb = strb;
   endtask

   task automatic test_reset();
      reset_l = 1'b0;
      #1;
      vectors++; if (bif.cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cmd_ready: got %b expected 0", bif.cmd_ready); end
      vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== 34'h0) begin miscompares++; $display("[TB] FAIL rst_rsp: got v=%b e=%b d=%h expected all 0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata); end
      vectors++; if ({bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wr_data} !== 69'h0) begin miscompares++; $display("[TB] FAIL rst_bus: got re=%b we=%h a=%h d=%h expected all 0", bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wr_data); end
      @(negedge clk);
      @(negedge clk);
      vectors++; if (bif.cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_held_cmd_ready: got %b expected 0", bif.cmd_ready); end
      reset_l = 1'b1;
      #1;
      vectors++; if (bif.cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_release_no_edge: got %b expected 0", bif.cmd_ready); end
      @(negedge clk);
      vectors++; if (bif.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_first_edge_ready: got %b expected 1", bif.cmd_ready); end
   endtask

   task automatic test_read_k1();
      issue(1'b0, 32'h0300_0000, 32'hFFFF_FFFF, 4'hF);
      bif.bus_rd_data = 32'h1111_1111;
      @(negedge clk); // cycle 1
      bif.cmd_valid = 1'b0;
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b1_0000) begin miscompares++; $display("[TB] FAIL rd_c1_req: got re=%b we=%h expected re=1 we=0", bif.bus_re, bif.bus_we); end
      vectors++; if (bif.bus_addr !== 32'h0300_0000) begin miscompares++; $display("[TB] FAIL rd_addr: got %h expected 03000000", bif.bus_addr); end
      vectors++; if ({bif.cmd_ready, bif.rsp_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL rd_c1_flags: got rdy=%b v=%b expected 0 0", bif.cmd_ready, bif.rsp_valid); end
      @(negedge clk); // cycle 2
      vectors++; if ({bif.bus_re, bif.rsp_valid} !== 2'b10) begin miscompares++; $display("[TB] FAIL rd_c2: got re=%b v=%b expected re=1 v=0", bif.bus_re, bif.rsp_valid); end
      bif.bus_rd_ack  = 1'b1;
      bif.bus_rd_data = 32'hCAFE_F00D;
      @(negedge clk); // cycle 3
      bif.bus_rd_ack  = 1'b0;
      bif.bus_rd_data = 32'h0;
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b0) begin miscompares++; $display("[TB] FAIL rd_c3_req_drop: got re=%b we=%h expected 0", bif.bus_re, bif.bus_we); end
      vectors++; if ({bif.rsp_valid, bif.rsp_err} !== 2'b10) begin miscompares++; $display("[TB] FAIL rd_c3_rsp: got v=%b e=%b expected v=1 e=0", bif.rsp_valid, bif.rsp_err); end
      vectors++; if (bif.rsp_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL rd_rdata: got %h expected cafef00d", bif.rsp_rdata); end
      bif.rsp_ready = 1'b1;
      @(negedge clk); // cycle 4
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_back_idle: got v=%b rdy=%b expected v=0 rdy=1", bif.rsp_valid, bif.cmd_ready); end
      last_addr = 32'h0300_0000;
   endtask

   task automatic test_write_zero_wait();
      issue(1'b1, 32'h0200_0000, 32'hA5A5_00FF, 4'h3);
      @(negedge clk); // cycle 1
      bif.cmd_valid = 1'b0;
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b0_0011) begin miscompares++; $display("[TB] FAIL wr_c1_req: got re=%b we=%h expected re=0 we=3", bif.bus_re, bif.bus_we); end
      vectors++; if ({bif.bus_addr, bif.bus_wr_data} !== {32'h0200_0000, 32'hA5A5_00FF}) begin miscompares++; $display("[TB] FAIL wr_addr_data: got %h/%h expected 02000000/a5a500ff", bif.bus_addr, bif.bus_wr_data); end
      bif.bus_wr_ack  = 1'b1;
      bif.bus_rd_data = 32'h1234_5678;
      @(negedge clk); // cycle 2
      bif.bus_wr_ack  = 1'b0;
      bif.bus_rd_data = 32'h0;
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b0) begin miscompares++; $display("[TB] FAIL wr_c2_req_drop: got re=%b we=%h expected 0", bif.bus_re, bif.bus_we); end
      vectors++; if ({bif.rsp_valid, bif.rsp_err} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_c2_rsp: got v=%b e=%b expected v=1 e=0", bif.rsp_valid, bif.rsp_err); end
      vectors++; if (bif.rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL wr_rdata: got %h expected 0", bif.rsp_rdata); end
      bif.rsp_ready = 1'b1;
      @(negedge clk); // cycle 3
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL wr_back_idle: got v=%b rdy=%b expected v=0 rdy=1", bif.rsp_valid, bif.cmd_ready); end
      last_addr = 32'h0200_0000;
   endtask

   task automatic test_timeout();
      issue(1'b0, 32'h0F00_0000, 32'h0, 4'h0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         bif.cmd_valid = 1'b0;
         vectors++; if ({bif.bus_re, bif.bus_we, bif.rsp_valid} !== 6'b1_0000_0) begin miscompares++; $display("[TB] FAIL to_wait_c%0d: got re=%b we=%h v=%b expected re=1 we=0 v=0", i, bif.bus_re, bif.bus_we, bif.rsp_valid); end
      end
      @(negedge clk); // cycle 5
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b0) begin miscompares++; $display("[TB] FAIL to_req_drop: got re=%b we=%h expected 0", bif.bus_re, bif.bus_we); end
      vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {2'b11, 32'h0}) begin miscompares++; $display("[TB] FAIL to_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata); end
      bif.bus_rd_ack  = 1'b1;
      bif.bus_rd_data = 32'hDEAD_BEEF;
      @(negedge clk); // cycle 6, late ack must be ignored
      vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.cmd_ready} !== {2'b11, 32'h0, 1'b0}) begin miscompares++; $display("[TB] FAIL to_late_ack: got v=%b e=%b d=%h rdy=%b expected v=1 e=1 d=0 rdy=0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.cmd_ready); end
      bif.bus_rd_ack  = 1'b0;
      bif.bus_rd_data = 32'h0;
      bif.rsp_ready   = 1'b1;
      @(negedge clk); // cycle 7
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL to_back_idle: got v=%b rdy=%b expected v=0 rdy=1", bif.rsp_valid, bif.cmd_ready); end
      last_addr = 32'h0F00_0000;
   endtask

   task automatic test_ack_at_timeout();
      issue(1'b0, 32'h0400_0010, 32'h0, 4'h0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         bif.cmd_valid = 1'b0;
         vectors++; if (bif.bus_re !== 1'b1) begin miscompares++; $display("[TB] FAIL race_wait_c%0d: got re=%b expected 1", i, bif.bus_re); end
      end
      @(negedge clk); // cycle 4: last wait cycle
      vectors++; if (bif.bus_re !== 1'b1) begin miscompares++; $display("[TB] FAIL race_wait_c4: got re=%b expected 1", bif.bus_re); end
      bif.bus_rd_ack  = 1'b1;
      bif.bus_rd_data = 32'h7777_0004;
      @(negedge clk); // cycle 5
      bif.bus_rd_ack  = 1'b0;
      bif.bus_rd_data = 32'h0;
      vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {2'b10, 32'h7777_0004}) begin miscompares++; $display("[TB] FAIL race_ack_wins: got v=%b e=%b d=%h expected v=1 e=0 d=77770004", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata); end
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL race_back_idle: got v=%b rdy=%b expected v=0 rdy=1", bif.rsp_valid, bif.cmd_ready); end
      last_addr = 32'h0400_0010;
   endtask

   task automatic test_wstrb_zero();
      issue(1'b1, 32'h0500_0000, 32'hFFFF_0000, 4'h0);
      @(negedge clk); // cycle 1
      bif.cmd_valid = 1'b0;
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b0) begin miscompares++; $display("[TB] FAIL nostrb_no_bus: got re=%b we=%h expected 0", bif.bus_re, bif.bus_we); end
      vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.cmd_ready} !== {2'b11, 32'h0, 1'b0}) begin miscompares++; $display("[TB] FAIL nostrb_rsp: got v=%b e=%b d=%h rdy=%b expected v=1 e=1 d=0 rdy=0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.cmd_ready); end
      vectors++; if (bif.bus_addr !== last_addr) begin miscompares++; $display("[TB] FAIL nostrb_addr_quiet: got %h expected %h", bif.bus_addr, last_addr); end
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready, bif.bus_re, bif.bus_we} !== 7'b01_0_0000) begin miscompares++; $display("[TB] FAIL nostrb_back_idle: got v=%b rdy=%b re=%b we=%h expected v=0 rdy=1 re=0 we=0", bif.rsp_valid, bif.cmd_ready, bif.bus_re, bif.bus_we); end
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 32'h0600_0000, 32'h0, 4'h0);
      @(negedge clk); // cycle 1
      bif.cmd_valid = 1'b0;
      vectors++; if (bif.bus_re !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_req: got re=%b expected 1", bif.bus_re); end
      bif.bus_rd_ack  = 1'b1;
      bif.bus_rd_data = 32'h5A5A_1234;
      @(negedge clk); // cycle 2: response waiting, consumer stalls
      bif.bus_rd_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.cmd_ready, bif.bus_re, bif.bus_we} !== {2'b10, 32'h5A5A_1234, 1'b0, 1'b0, 4'h0}) begin miscompares++; $display("[TB] FAIL hold_c%0d: got v=%b e=%b d=%h rdy=%b re=%b we=%h expected v=1 e=0 d=5a5a1234 rdy=0 re=0 we=0", i, bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.cmd_ready, bif.bus_re, bif.bus_we); end
         issue(1'b1, 32'h0700_0000, 32'h1357_9BDF, 4'hC);
         bif.bus_wr_ack  = i[0];
         bif.bus_rd_data = 32'h0101_0101 * (i + 1);
         @(negedge clk);
      end
      bif.bus_wr_ack  = 1'b0;
      bif.bus_rd_data = 32'h0;
      vectors++; if ({bif.rsp_valid, bif.rsp_rdata} !== {1'b1, 32'h5A5A_1234}) begin miscompares++; $display("[TB] FAIL hold_end: got v=%b d=%h expected v=1 d=5a5a1234", bif.rsp_valid, bif.rsp_rdata); end
      bif.rsp_ready = 1'b1;
      @(negedge clk); // idle cycle, second command offered and accepted here
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready, bif.bus_re, bif.bus_we} !== 7'b01_0_0000) begin miscompares++; $display("[TB] FAIL b2b_idle_gap: got v=%b rdy=%b re=%b we=%h expected v=0 rdy=1 re=0 we=0", bif.rsp_valid, bif.cmd_ready, bif.bus_re, bif.bus_we); end
      @(negedge clk);
      bif.cmd_valid = 1'b0;
      vectors++; if ({bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wr_data} !== {1'b0, 4'hC, 32'h0700_0000, 32'h1357_9BDF}) begin miscompares++; $display("[TB] FAIL b2b_second_req: got re=%b we=%h a=%h d=%h expected re=0 we=c a=07000000 d=13579bdf", bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wr_data); end
      bif.bus_wr_ack = 1'b1;
      @(negedge clk);
      bif.bus_wr_ack = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.bus_we} !== {2'b10, 32'h0, 4'h0}) begin miscompares++; $display("[TB] FAIL b2b_second_rsp: got v=%b e=%b d=%h we=%h expected v=1 e=0 d=0 we=0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata, bif.bus_we); end
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      vectors++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin miscompares++; $display("[TB] FAIL b2b_back_idle: got v=%b rdy=%b expected v=0 rdy=1", bif.rsp_valid, bif.cmd_ready); end
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 32'h0800_0000, 32'h2468_ACE0, 4'hF);
      @(negedge clk); // cycle 1
      bif.cmd_valid = 1'b0;
      vectors++; if ({bif.bus_re, bif.bus_we} !== 5'b0_1111) begin miscompares++; $display("[TB] FAIL mid_req: got re=%b we=%h expected re=0 we=f", bif.bus_re, bif.bus_we); end
      #2;
      reset_l = 1'b0;
      #1;
      vectors++; if ({bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wr_data} !== 69'h0) begin miscompares++; $display("[TB] FAIL mid_async_drop: got re=%b we=%h a=%h d=%h expected all 0", bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wr_data); end
      vectors++; if ({bif.cmd_ready, bif.rsp_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_flags: got rdy=%b v=%b expected 0 0", bif.cmd_ready, bif.rsp_valid); end
      @(negedge clk);
      reset_l = 1'b1;
      bif.bus_wr_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bif.bus_wr_ack = 1'b0;
         vectors++; if ({bif.rsp_valid, bif.cmd_ready, bif.bus_re, bif.bus_we} !== 7'b01_0_0000) begin miscompares++; $display("[TB] FAIL mid_after_c%0d: got v=%b rdy=%b re=%b we=%h expected v=0 rdy=1 re=0 we=0", i, bif.rsp_valid, bif.cmd_ready, bif.bus_re, bif.bus_we); end
      end
   endtask

   initial begin
      idle_inputs();
      last_addr = 32'h0;
      test_reset();
      test_read_k1();
      test_write_zero_wait();
      test_timeout();
      test_ack_at_timeout();
      test_wstrb_zero();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter: TIMEOUT, default 255, meaning bus cycles allowed for an ack before the transaction is abandoned (range 1..65535).
REQ-002 Port: clk  in  1  single clock for all logic.
REQ-003 Port: reset_l  in  1  reset, asynchronous, active-low.
REQ-004 Port: cmd_valid  in  1  command offered.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk rise.
REQ-006 Port: cmd_write  in  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr  in  32  byte address, passed to bus unmodified.
REQ-008 Port: cmd_wdata  in  32  write data.
REQ-009 Port: cmd_wstrb  in  4  byte-lane enables for writes; ignored for reads.
REQ-010 Port: rsp_valid  out  1  response available.
REQ-011 Port: rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at clk rise.
REQ-012 Port: rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-013 Port: rsp_err  out  1  1 = timeout or illegal command.
REQ-014 Port: bus_we  out  4  bus write strobes, packed into the bus_in WE field by the integrator.
REQ-015 Port: bus_re  out  1  bus read request, packed into bus_in RE.
REQ-016 Port: bus_addr  out  32  bus address, packed into bus_in ADDR.
REQ-017 Port: bus_wr_data  out  32  bus write data, packed into bus_in WR_DATA.
REQ-018 Port: bus_rd_data  in  32  from bus_out RD_DATA (OR of all responders).
REQ-019 Port: bus_rd_ack  in  1  from bus_out RD_ACK.
REQ-020 Port: bus_wr_ack  in  1  from bus_out WR_ACK.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, REQ and RSP.
REQ-022 In IDLE, cmd_ready SHALL be 1; in REQ and RSP it SHALL be 0.
REQ-023 On accept of a read, or of a write with cmd_wstrb != 0, the block SHALL latch the command and enter REQ; bus_re or bus_we SHALL be driven starting the next cycle.
REQ-024 On accept of a write with cmd_wstrb == 0, the block SHALL make no bus access and SHALL enter RSP with rsp_err=1 and rsp_rdata=0.
REQ-025 In REQ, bus_addr, bus_wr_data, bus_re and bus_we SHALL be registered outputs and SHALL be held stable until the ack cycle.
- read: bus_re=1, bus_we=0;
- write: bus_we=latched wstrb, bus_re=0.
REQ-026 Either bus_rd_ack or bus_wr_ack SHALL be accepted as completion, matching the ORed ready of the CPU path.
REQ-027 On the cycle an ack is sampled in REQ, the block SHALL:
- capture bus_rd_data (reads) or 0 (writes) into rsp_rdata;
- set rsp_err=0;
- clear bus_re and bus_we at the next edge;
- enter RSP.
REQ-028 Acks sampled outside REQ SHALL be ignored.
REQ-029 A 16-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-030 When the wait counter equals TIMEOUT-1 with no ack, the block SHALL drop the bus request and enter RSP with rsp_err=1 and rsp_rdata=0.
REQ-031 If an ack and the timeout occur in the same cycle, the ack SHALL win (rsp_err=0).
REQ-032 In RSP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL be held until rsp_ready; on handshake the block SHALL return to IDLE.
REQ-033 Bus request outputs SHALL be 0 in IDLE and RSP, guaranteeing at least one idle bus cycle between transactions.
REQ-034 Latency for a responder acking k cycles after request assertion (k>=0) SHALL be:
- accept at cycle 0;
- request visible at cycle 1;
- rsp_valid at cycle k+2.
REQ-035 bus_addr and bus_wr_data values outside REQ are don't-care, but SHALL not toggle while bus_re/bus_we=0, to limit switching.

Reset
REQ-036 Asserting reset_l low at any time SHALL force, asynchronously:
- state=IDLE;
- cmd_ready=0 while reset_l is low, then 1 from the first clk after deassertion;
- rsp_valid=0, rsp_err=0, rsp_rdata=0;
- bus_re=0, bus_we=0, bus_addr=0, bus_wr_data=0;
- wait counter=0.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no response produced.

Verification
REQ-038 Read, responder acks k=1: addr 0x0300_0000 -> bus_re=1 for 2 cycles; rsp_valid at cycle 3; rsp_rdata=ack-cycle bus_rd_data; rsp_err=0.
REQ-039 Write with wdata 0xA5A5_00FF, wstrb 0x3 to 0x0200_0000, zero-wait ack -> bus_we=0x3 for exactly 1 cycle; rsp_valid at cycle 2; rsp_rdata=0; rsp_err=0.
REQ-040 TIMEOUT=4, read of an unmapped address (no ack) -> bus_re=1 for exactly 4 cycles; then rsp_err=1, rsp_rdata=0; the next command is accepted after rsp handshake.
REQ-041 Write with wstrb=0 -> no bus_we/bus_re pulse; rsp_valid next cycle with rsp_err=1.
REQ-042 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_rdata stable; cmd_ready=0 throughout; back-to-back commands show >=1 idle bus cycle.
REQ-043 reset_l pulsed low during REQ -> bus_re/bus_we drop without a clk edge; no rsp_valid; cmd_ready=1 after release.
